muldiv_unit: RTL
================

# muldiv_unit

Parametrised iterative multiply/divide unit for the multicycle CPU datapath, replacing the separate fixed-32-bit multiplier and divider. It takes operands from the A/B registers on a `start` pulse from the control unit and runs a radix-2 shift-add or restoring-divide loop. It then delivers HI/LO results with a one-cycle `ready` pulse. It adds signed/unsigned modes, a divide-by-zero flag, abort, and a configurable operand width that the fixed units lack.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits; minimum 4.
- `clk` input 1: sole clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only in IDLE.
- `op` input 2: operation. 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `a` input WIDTH: multiplicand or dividend.
- `b` input WIDTH: multiplier or divisor.
- `abort` input 1: cancel the operation in flight.
- `hi` output WIDTH: product upper half, or remainder.
- `lo` output WIDTH: product lower half, or quotient.
- `busy` output 1: high while an operation is in flight.
- `ready` output 1: one-cycle completion pulse.
- `div_zero` output 1: last accepted operation was a divide with `b`==0.

## Operation
- States and transitions:
  - IDLE, RUN, FIX.
  - IDLE→RUN on `start` at a clock edge.
  - RUN→FIX after the last iteration.
  - FIX→IDLE always.
- At the start edge:
  - Latch `op` and the operand magnitudes (`a`, `b` as-is when unsigned; two's-complement absolute values when signed).
  - Latch the result sign: multiply, sign(a) XOR sign(b); quotient, sign(a) XOR sign(b); remainder, sign(a).
  - Clear the iteration counter and clear `div_zero`.
- RUN iterations, one per clock:
  - Multiply: shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator.
  - Divide: restoring divide, one quotient bit per cycle.
  - WIDTH iterations unless the configuration macro below applies.
- FIX cycle:
  - Negate magnitudes as latched.
  - Write `hi`/`lo` at the FIX→IDLE edge and assert `ready` for exactly that following cycle.
- Signed divide semantics:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Most-negative ÷ −1: `lo` = most-negative value, `hi` = 0, no flag.
- Divide by zero (`op`[1]=1, `b`==0):
  - Start edge goes IDLE→FIX directly; RUN is skipped.
  - Next edge: `ready`=1, `div_zero`=1; `hi`/`lo` keep their previous values.
- Output persistence:
  - `hi`/`lo` change only at a FIX→IDLE edge of a completed operation and are held otherwise.
  - `div_zero` is held until the next accepted `start`.
- `start` outside IDLE is ignored.
- `start` in the `ready` cycle (state IDLE) is accepted (back-to-back operation).
- `abort` in RUN or FIX:
  - Next edge goes to IDLE with no `ready` pulse.
  - `hi`/`lo`/`div_zero` are unchanged.
  - `abort` in IDLE has no effect.
  - `abort` and `start` together in IDLE: `start` wins.
- Reset (asynchronous, any state):
  - `hi`=0, `lo`=0, `busy`=0, `ready`=0, `div_zero`=0, state IDLE, internal accumulators cleared.
  - Reset mid-operation discards the operation.

## Timing
- Start sampled at edge N.
- `busy`=1 from after edge N until the FIX→IDLE edge; it is 0 in the `ready` cycle.
- Normal operation: RUN occupies edges N+1 … N+WIDTH; FIX edge is N+WIDTH+1; `ready` and new `hi`/`lo` are visible after edge N+WIDTH+1 (WIDTH+1 cycles of latency; 33 when WIDTH=32).
- Divide by zero: `ready` is visible after edge N+1.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `MULDIV_EARLY_TERM_EN`.
- Defined:
  - Multiply leaves RUN as soon as the remaining (unshifted) multiplier-magnitude bits are all zero, after at least 1 iteration.
  - Latency is (position of the highest set bit of |b|) + 1 iterations, minimum 1, plus FIX.
  - Multiply by zero takes 1 iteration.
  - Divide is unaffected.
- Undefined: fixed WIDTH iterations for every operation.

## Test plan
All values below use WIDTH=32.

1. MULT a=0xFFFFFFFD (−3), b=5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1, `ready` visible after edge N+33, `busy` low in the `ready` cycle.
2. DIVU 100/7 → `lo`=14, `hi`=2. DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
3. DIVU 9/0 after a prior result hi=2, lo=14 → `ready` and `div_zero` after edge N+1, `hi`=2, `lo`=14 unchanged; the next valid `start` clears `div_zero`.
4. MULTU 6×7 started, `abort` asserted at N+10 → no `ready`, `busy` low after N+11, `hi`/`lo` unchanged. Then `start` issued in the same cycle as `ready` of a further op → second op accepted, two `ready` pulses 34 cycles apart.
5. `reset_n` pulsed low mid-RUN (asynchronously, between edges) → all outputs 0 immediately; a subsequent MULTU 3×5 gives `lo`=15, `hi`=0.
6. With `MULDIV_EARLY_TERM_EN` defined: MULTU 3×5 → `ready` after edge N+4 (3 iterations + FIX), `lo`=15. MULTU x×0 → `ready` after edge N+2. DIVU latency still 33.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the control unit and muldiv_unit.
// master drives operands and control; slave returns HI/LO and status.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             abort;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             ready;
   logic             div_zero;

   modport master (
      output start, op, a, b, abort,
      input  hi, lo, busy, ready, div_zero
   );

   modport slave (
      input  start, op, a, b, abort,
      output hi, lo, busy, ready, div_zero
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide with HI/LO results.
// Define MULDIV_EARLY_TERM_EN to end multiplies once the multiplier runs out.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          reset_n,
   muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CW-1:0]      cnt;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic               sign_p;
   logic               sign_r;
   logic               dz_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               busy_q;
   logic               ready_q;
   logic               dz_out;

   logic               in_signed;
   logic               b_zero;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic               is_div;
   logic               mul_last;
   logic               last;
   logic [2*WIDTH-1:0] mul_sum;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign in_signed = ~bus.op[0];
   assign b_zero    = (bus.b == '0);
   assign abs_a     = (in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign abs_b     = (in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
   assign is_div    = op_q[1];

`ifdef MULDIV_EARLY_TERM_EN
   assign mul_last = ~|mplier[WIDTH-1:1];
`else
   assign mul_last = 1'b0;
`endif

   assign last    = (cnt == LAST) || (!is_div && mul_last);
   assign mul_sum = acc + (mplier[0] ? mcand : '0);

   // Remainder lives in the upper half, dividend/quotient bits in the lower.
   assign shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign diff     = shifted - {1'b0, mplier};
   assign div_next = diff[WIDTH]
                   ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                   : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

   assign prod_fix = sign_p ? -acc : acc;
   assign quo_fix  = sign_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_fix  = sign_r ? -acc[2*WIDTH-1:WIDTH]
                            : acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (bus.start)
               state_nxt = (bus.op[1] && b_zero) ? FIX : RUN;
         end
         RUN: begin
            if (bus.abort) state_nxt = IDLE;
            else if (last) state_nxt = FIX;
         end
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         op_q    <= '0;
         mplier  <= '0;
         acc     <= '0;
         mcand   <= '0;
         sign_p  <= 1'b0;
         sign_r  <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         dz_out  <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         busy_q  <= (state_nxt != IDLE);
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  op_q   <= bus.op;
                  cnt    <= '0;
                  dz_out <= 1'b0;
                  dz_q   <= bus.op[1] && b_zero;
                  sign_p <= in_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  sign_r <= in_signed & bus.a[WIDTH-1];
                  mplier <= abs_b;
                  mcand  <= {{WIDTH{1'b0}}, abs_a};
                  acc    <= bus.op[1] ? {{WIDTH{1'b0}}, abs_a} : '0;
               end
            end
            RUN: begin
               if (!bus.abort) begin
                  cnt <= cnt + CW'(1);
                  if (is_div) begin
                     acc <= div_next;
                  end else begin
                     acc    <= mul_sum;
                     mcand  <= mcand << 1;
                     mplier <= mplier >> 1;
                  end
               end
            end
            FIX: begin
               if (!bus.abort) begin
                  ready_q <= 1'b1;
                  if (dz_q) begin
                     dz_out <= 1'b1;
                  end else if (is_div) begin
                     hi_q <= rem_fix;
                     lo_q <= quo_fix;
                  end else begin
                     hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                     lo_q <= prod_fix[WIDTH-1:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign bus.busy     = busy_q;
   assign bus.ready    = ready_q;
   assign bus.div_zero = dz_out;
endmodule
